pll_lock_seq: RTL and testbench

PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

---
 rtl/pll_lock_seq.sv | 178 +++++++++++++++++
 tb/tb_pll_lock_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_seq.sv
// PLL power-up/lock sequencer: powers the PLL down, resets it, waits for a stable
// lock and then enables the downstream clock buffers, retrying a bounded number of times.
//
// state     | meaning
// ----------+------------------------------------------------------
// PWD   (0) | PLL powered down, timed by PWD_CYC
// RST   (1) | PLL powered, held in reset for RST_CYC
// WAIT  (2) | waiting for lock_s, bounded by LOCK_TIMEOUT
// STABLE(3) | lock_s must stay high for STABLE_CYC cycles
// RUN   (4) | locked, clocks enabled
// FAIL  (5) | retries exhausted, waits for relock_req
module pll_lock_seq #(
  parameter int PWD_CYC      = 5,
  parameter int RST_CYC      = 5,
  parameter int LOCK_TIMEOUT = 20000,
  parameter int STABLE_CYC   = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clkin1,
  input  logic       rst,
  input  logic       lock,
  input  logic       relock_req,
  input  logic       clear_err,
  output logic       pll_pwd,
  output logic       pll_rst,
  output logic       clkout_en,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] relock_cnt,
  output logic [2:0] state
);

  localparam logic [2:0] S_PWD    = 3'd0;
  localparam logic [2:0] S_RST    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_STABLE = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  localparam int TMAX = (LOCK_TIMEOUT > PWD_CYC) ?
                        ((LOCK_TIMEOUT > RST_CYC) ? LOCK_TIMEOUT : RST_CYC) :
                        ((PWD_CYC > RST_CYC) ? PWD_CYC : RST_CYC);
  localparam int TW = $clog2(TMAX + 1);
  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] PWD_T  = TW'(PWD_CYC);
  localparam logic [TW-1:0] RST_T  = TW'(RST_CYC);
  localparam logic [TW-1:0] TO_T   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STB_T  = SW'(STABLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_T = RW'(MAX_RETRY);

  logic          lock_m, lock_s;
  logic [2:0]    state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [SW-1:0] stb, stb_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic          lost_evt;

  // tmr counts elapsed cycles in PWD/RST; a transition edge into PWD is its first cycle
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    stb_nxt   = stb;
    retry_nxt = retry;
    lost_evt  = 1'b0;
    case (state)
      S_PWD: begin
        if (tmr == PWD_T) begin
          state_nxt = S_RST;
          tmr_nxt   = TW'(1);
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      S_RST: begin
        if (tmr == RST_T) begin
          state_nxt = S_WAIT;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      S_WAIT: begin
        if (lock_s) begin
          state_nxt = S_STABLE;
          stb_nxt   = '0;
        end else if (tmr == TO_T) begin
          if (retry < RETRY_T) begin
            retry_nxt = retry + 1'b1;
            state_nxt = S_PWD;
            tmr_nxt   = TW'(1);
          end else begin
            state_nxt = S_FAIL;
            tmr_nxt   = '0;
          end
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_nxt = S_WAIT;
          tmr_nxt   = '0;
        end else if (stb == STB_T) begin
          state_nxt = S_RUN;
          retry_nxt = '0;
        end else begin
          stb_nxt = stb + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          lost_evt  = 1'b1;
          state_nxt = S_PWD;
          tmr_nxt   = TW'(1);
        end else if (relock_req) begin
          state_nxt = S_PWD;
          tmr_nxt   = TW'(1);
        end
      end
      S_FAIL: begin
        if (relock_req) begin
          state_nxt = S_PWD;
          tmr_nxt   = TW'(1);
          retry_nxt = '0;
        end
      end
      default: begin
        state_nxt = S_PWD;
        tmr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clkin1) begin
    if (rst) begin
      lock_m     <= 1'b0;
      lock_s     <= 1'b0;
      state      <= S_PWD;
      tmr        <= '0;
      stb        <= '0;
      retry      <= '0;
      pll_pwd    <= 1'b1;
      pll_rst    <= 1'b1;
      clkout_en  <= 1'b0;
      ready      <= 1'b0;
      fail       <= 1'b0;
      lock_lost  <= 1'b0;
      relock_cnt <= 4'd0;
    end else begin
      lock_m    <= lock;
      lock_s    <= lock_m;
      state     <= state_nxt;
      tmr       <= tmr_nxt;
      stb       <= stb_nxt;
      retry     <= retry_nxt;
      pll_pwd   <= (state_nxt == S_PWD);
      pll_rst   <= (state_nxt == S_PWD) || (state_nxt == S_RST);
      clkout_en <= (state_nxt == S_RUN);
      ready     <= (state_nxt == S_RUN);
      fail      <= (state_nxt == S_FAIL);
      // a loss in the same cycle as clear_err wins and restarts the count at 1
      if (lost_evt) begin
        lock_lost <= 1'b1;
        if (clear_err)
          relock_cnt <= 4'd1;
        else if (relock_cnt != 4'd15)
          relock_cnt <= relock_cnt + 4'd1;
      end else if (clear_err) begin
        lock_lost  <= 1'b0;
        relock_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_seq.sv
// Bench for pll_lock_seq: timestamp-based reference model checked every cycle,
// directed sequences with hand-computed edge numbers, then randomized lock/request traffic.
module tb_pll_lock_seq;
  localparam int PWD_CYC = 4, RST_CYC = 4, LOCK_TIMEOUT = 32, STABLE_CYC = 8, MAX_RETRY = 2;

  logic clkin1 = 1'b0, rst = 1'b1, lock = 1'b0, relock_req = 1'b0, clear_err = 1'b0;
  logic pll_pwd, pll_rst, clkout_en, ready, fail, lock_lost;
  logic [3:0] relock_cnt;
  logic [2:0] state;

  pll_lock_seq #(.PWD_CYC(PWD_CYC), .RST_CYC(RST_CYC), .LOCK_TIMEOUT(LOCK_TIMEOUT),
                 .STABLE_CYC(STABLE_CYC), .MAX_RETRY(MAX_RETRY)) dut (
    .clkin1(clkin1), .rst(rst), .lock(lock), .relock_req(relock_req), .clear_err(clear_err),
    .pll_pwd(pll_pwd), .pll_rst(pll_rst), .clkout_en(clkout_en), .ready(ready), .fail(fail),
    .lock_lost(lock_lost), .relock_cnt(relock_cnt), .state(state));

  always #5 clkin1 = ~clkin1;

  int total = 0, bad = 0, cyc = 0, t0 = 0;

  // model: current phase plus the edge index at which it began
  int m_st = 0, m_enter = 0, m_retry = 0, m_lost = 0, m_rcnt = 0, m_lk1 = 0, m_lk2 = 0;
  int m_el, m_ls, m_loss;
  bit m_valid = 1'b0;
  logic [12:0] got_v, exp_v;

  always @(posedge clkin1) begin
    cyc = cyc + 1;
    if (rst) begin
      m_valid = 1'b1;
      m_st = 0; m_enter = cyc + 1; m_retry = 0; m_lost = 0; m_rcnt = 0; m_lk1 = 0; m_lk2 = 0;
    end else begin
      m_el = cyc - m_enter;
      m_ls = m_lk2;
      m_loss = 0;
      case (m_st)
        0: if (m_el == PWD_CYC) begin m_st = 1; m_enter = cyc; end
        1: if (m_el == RST_CYC) begin m_st = 2; m_enter = cyc; end
        2: if (m_ls != 0) begin
             m_st = 3; m_enter = cyc;
           end else if (m_el == LOCK_TIMEOUT) begin
             if (m_retry < MAX_RETRY) begin m_retry++; m_st = 0; end
             else m_st = 5;
             m_enter = cyc;
           end
        3: if (m_ls == 0) begin m_st = 2; m_enter = cyc; end
           else if (m_el == STABLE_CYC) begin m_st = 4; m_retry = 0; m_enter = cyc; end
        4: if (m_ls == 0) begin m_loss = 1; m_st = 0; m_enter = cyc; end
           else if (relock_req) begin m_st = 0; m_enter = cyc; end
        5: if (relock_req) begin m_st = 0; m_enter = cyc; m_retry = 0; end
        default: m_st = 0;
      endcase
      if (m_loss != 0) begin
        m_lost = 1;
        m_rcnt = clear_err ? 1 : ((m_rcnt < 15) ? m_rcnt + 1 : 15);
      end else if (clear_err) begin
        m_lost = 0; m_rcnt = 0;
      end
      m_lk2 = m_lk1;
      m_lk1 = lock ? 1 : 0;
    end
    #1;
    if (m_valid) begin
      got_v = {pll_pwd, pll_rst, clkout_en, ready, fail, lock_lost, relock_cnt, state};
      exp_v = {(m_st == 0), (m_st <= 1), (m_st == 4), (m_st == 4), (m_st == 5),
               (m_lost != 0), 4'(m_rcnt), 3'(m_st)};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL model_cycle %0d outputs got=%h exp=%h", cyc, got_v, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (edge %0d)", nm, got, exp, cyc - t0);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk(nm, int'({pll_pwd, pll_rst, clkout_en, ready, fail, lock_lost, relock_cnt, state}),
        int'(13'b1_1000_0000_0000));
  endtask

  task automatic release_rst();
    @(negedge clkin1);
    rst = 1'b1; lock = 1'b0; relock_req = 1'b0; clear_err = 1'b0;
    repeat (2) @(negedge clkin1);
    chk_reset_vals("reset_values");
    rst = 1'b0;
    t0 = cyc + 1;
  endtask

  task automatic at_edge(input int e);
    while (cyc < t0 + e) @(negedge clkin1);
  endtask

  task automatic wait_run(input string nm);
    int w = 0;
    while (state !== 3'd4 && w < 200) begin @(negedge clkin1); w++; end
    chk(nm, int'(state), 4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // normal start, loss in RUN, clear_err, relock_req, rst in RUN
    release_rst();
    at_edge(3);   chk("pwd_e3", pll_pwd, 1);
    at_edge(4);   chk("pwd_e4", pll_pwd, 0);
    at_edge(7);   chk("prst_e7", pll_rst, 1);
    at_edge(8);   chk("prst_e8", pll_rst, 0); chk("wait_e8", state, 2);
    at_edge(19);  lock = 1'b1;
    at_edge(29);  chk("ready_e29", ready, 0); chk("stable_e29", state, 3);
    at_edge(30);  chk("ready_e30", ready, 1); chk("en_e30", clkout_en, 1); chk("fail_e30", fail, 0);
    at_edge(40);  lock = 1'b0;
    at_edge(42);  chk("en_e42", clkout_en, 1);
    at_edge(43);  chk("en_e43", clkout_en, 0); chk("pwd_st_e43", state, 0);
                  chk("lost_e43", lock_lost, 1); chk("rcnt_e43", relock_cnt, 1);
    at_edge(59);  lock = 1'b1;
    at_edge(70);  chk("relock_run_e70", state, 4); chk("lost_kept_e70", lock_lost, 1);
    at_edge(75);  clear_err = 1'b1;
    at_edge(76);  clear_err = 1'b0;
                  chk("clr_lost", lock_lost, 0); chk("clr_rcnt", relock_cnt, 0);
    at_edge(80);  lock = 1'b0;
    at_edge(82);  clear_err = 1'b1;
    at_edge(83);  clear_err = 1'b0;
                  chk("clr_loss_lost", lock_lost, 1); chk("clr_loss_rcnt", relock_cnt, 1);
    at_edge(99);  lock = 1'b1;
    at_edge(110); chk("run_e110", state, 4);
    at_edge(115); relock_req = 1'b1;
    at_edge(116); relock_req = 1'b0;
                  chk("req_pwd", state, 0); chk("req_lost", lock_lost, 1); chk("req_rcnt", relock_cnt, 1);
    at_edge(133); chk("req_rerun", state, 4);
    at_edge(140); rst = 1'b1;
    at_edge(141); chk_reset_vals("rst_in_run"); rst = 1'b0;

    // glitch during STABLE
    release_rst();
    at_edge(19);  lock = 1'b1;
    at_edge(24);  lock = 1'b0;
    at_edge(27);  lock = 1'b1; chk("glitch_wait", state, 2); chk("glitch_ready", ready, 0);
    at_edge(37);  chk("glitch_e37", ready, 0);
    at_edge(38);  chk("glitch_e38", ready, 1); chk("glitch_lost", lock_lost, 0);

    // no lock, FAIL, relock_req, fresh attempts
    release_rst();
    at_edge(0);   chk("nl_pwd0", pll_pwd, 1);
    at_edge(39);  chk("nl_st39", state, 2); chk("nl_pwd39", pll_pwd, 0);
    at_edge(40);  chk("nl_pwd40", pll_pwd, 1);
    at_edge(80);  chk("nl_pwd80", pll_pwd, 1);
    at_edge(119); chk("nl_st119", state, 2); chk("nl_fail119", fail, 0);
    at_edge(120); chk("nl_st120", state, 5); chk("nl_fail120", fail, 1);
    at_edge(125); relock_req = 1'b1;
    at_edge(126); relock_req = 1'b0; chk("fr_pwd", state, 0); chk("fr_fail", fail, 0);
    at_edge(166); chk("fr_att2", state, 0);
    at_edge(206); chk("fr_att3", state, 0);
    at_edge(225); lock = 1'b1;
    at_edge(236); chk("fr_run", state, 4); chk("fr_ready", ready, 1);

    // rst mid-WAIT_LOCK
    release_rst();
    at_edge(15);  rst = 1'b1;
    at_edge(16);  chk_reset_vals("rst_in_wait"); rst = 1'b0;

    // relock_cnt saturation over 16 losses
    release_rst();
    lock = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_run("sat_run");
      lock = 1'b0;
      repeat (3) @(negedge clkin1);
      lock = 1'b1;
    end
    wait_run("sat_run_final");
    chk("sat_rcnt", relock_cnt, 15);
    chk("sat_lost", lock_lost, 1);

    // randomized traffic, checked by the model every cycle
    begin
      int hold = 0;
      for (int n = 0; n < 3000; n++) begin
        @(negedge clkin1);
        if (hold == 0) begin
          lock = ($urandom_range(0, 99) < 70);
          hold = $urandom_range(1, 50);
        end else begin
          hold--;
        end
        relock_req = ($urandom_range(0, 39) == 0);
        clear_err  = ($urandom_range(0, 299) == 0);
        rst        = ($urandom_range(0, 1999) == 0);
      end
      @(negedge clkin1);
      rst = 1'b0; relock_req = 1'b0; clear_err = 1'b0;
      repeat (3) @(negedge clkin1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
